exception_ctrl: RTL

- Exception control stage downstream of the main decoder in the pipelined LEGv8 core.
- Consumes the pipelined Exc/EStatus/ERet flags and the faulting PC.
- Captures the exception system registers ELR, ESR and ERR, then redirects fetch to the handler vector or back to ELR.
- Drives ExcAck and the pipeline flush. Serves MRS reads of ELR/ESR/ERR.

---
 rtl/exc_pkg.sv | 26 ++
 rtl/exception_ctrl_if.sv | 27 ++
 rtl/exc_sysregs.sv | 72 +++++++
 rtl/exception_ctrl.sv | 90 +++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared types and constants for the exception control stage.
// Holds the FSM state enum, fetch-select encodings and cause codes.
package exc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKE    = 2'd1,
        HANDLER = 2'd2,
        RETURN  = 2'd3
    } exc_state_t;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_VEC = 2'b01;
    localparam logic [1:0] PC_ELR = 2'b10;

    localparam logic [3:0] IRQ_CODE   = 4'b0001;
    localparam logic [3:0] UNDEF_CODE = 4'b0010;

    localparam int NESTED_BIT = 4;

    localparam logic [1:0] SEL_ELR = 2'b00;
    localparam logic [1:0] SEL_ESR = 2'b01;
    localparam logic [1:0] SEL_ERR = 2'b10;
    localparam logic [1:0] SEL_CNT = 2'b11;

endpackage

// File: rtl/exception_ctrl_if.sv
// Pipeline-facing bundle of the exception stage: memory-stage flags in,
// redirect/flush/MRS data out. master = pipeline side, slave = exception_ctrl.
interface exception_ctrl_if #(
    parameter int N = 64
);
    logic         Exc_M;
    logic [3:0]   EStatus_M;
    logic         ERet_M;
    logic [N-1:0] PC_M;
    logic [1:0]   SysRegSel;
    logic [N-1:0] SysRegData;
    logic         ExcAck;
    logic         Flush;
    logic [1:0]   PCSel;
    logic [N-1:0] ExcPC;
    logic         InHandler;

    modport master (
        output Exc_M, EStatus_M, ERet_M, PC_M, SysRegSel,
        input  SysRegData, ExcAck, Flush, PCSel, ExcPC, InHandler
    );

    modport slave (
        input  Exc_M, EStatus_M, ERet_M, PC_M, SysRegSel,
        output SysRegData, ExcAck, Flush, PCSel, ExcPC, InHandler
    );
endinterface

// File: rtl/exc_sysregs.sv
// Exception system registers ELR/ESR/ERR plus a saturating exception counter.
// Loads take effect on the next edge; MRS read mux is purely combinational.
module exc_sysregs
    import exc_pkg::*;
#(
    parameter int N     = 64,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld_elr,
    input  logic         ld_cause,
    input  logic         cnt_inc,
    input  logic [N-1:0] elr_in,
    input  logic [N-1:0] esr_in,
    input  logic [N-1:0] err_in,
    input  logic [1:0]   sel,
    output logic [N-1:0] rd_dat,
    output logic [N-1:0] elr
);

    logic [N-1:0]     elr_q, elr_d;
    logic [N-1:0]     esr_q, esr_d;
    logic [N-1:0]     err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        elr_d = elr_q;
        esr_d = esr_q;
        err_d = err_q;
        cnt_d = cnt_q;
        if (ld_elr) begin
            elr_d = elr_in;
        end
        if (ld_cause) begin
            esr_d = esr_in;
            err_d = err_in;
        end
        // Counter sticks at all-ones instead of wrapping back to zero.
        if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elr_q <= '0;
            esr_q <= '0;
            err_q <= '0;
            cnt_q <= '0;
        end else begin
            elr_q <= elr_d;
            esr_q <= esr_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        rd_dat = '0;
        unique case (sel)
            SEL_ELR: rd_dat = elr_q;
            SEL_ESR: rd_dat = esr_q;
            SEL_ERR: rd_dat = err_q;
            SEL_CNT: rd_dat = N'(cnt_q);
            default: rd_dat = '0;
        endcase
    end

    assign elr = elr_q;

endmodule

// File: rtl/exception_ctrl.sv
// Exception control FSM: captures ELR/ESR/ERR and redirects fetch to the vector or ELR.
// Redirect appears 1 cycle after Exc_M/ERet_M is sampled; inputs are ignored while redirecting.
module exception_ctrl #(
    parameter int           N          = 64,
    parameter logic [N-1:0] EXC_VECTOR = 'hD8,
    parameter logic [3:0]   IRQ_CODE   = 4'b0001,
    parameter int           CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    exception_ctrl_if.slave  bus
);
    import exc_pkg::*;

    exc_state_t   state_q, state_d;
    logic         ld_elr;
    logic         ld_cause;
    logic [N-1:0] elr_nxt;
    logic [N-1:0] esr_nxt;
    logic [N-1:0] elr;

    // An interrupt returns past the interrupted instruction; a fault re-executes it.
    assign elr_nxt = (bus.EStatus_M == IRQ_CODE) ? (bus.PC_M + N'(4)) : bus.PC_M;

    always_comb begin
        state_d    = state_q;
        ld_elr     = 1'b0;
        ld_cause   = 1'b0;
        esr_nxt    = '0;
        esr_nxt[3:0] = bus.EStatus_M;
        unique case (state_q)
            IDLE: begin
                if (bus.Exc_M) begin
                    ld_elr   = 1'b1;
                    ld_cause = 1'b1;
                    state_d  = TAKE;
                end
            end
            TAKE: state_d = HANDLER;
            HANDLER: begin
                // IRQs are masked in the handler; other faults nest but keep the original ELR.
                if (bus.Exc_M) begin
                    if (bus.EStatus_M != IRQ_CODE) begin
                        ld_cause            = 1'b1;
                        esr_nxt[NESTED_BIT] = 1'b1;
                        state_d             = TAKE;
                    end
                end else if (bus.ERet_M) begin
                    state_d = RETURN;
                end
            end
            RETURN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    exc_sysregs #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_sysregs (
        .clk      (clk),
        .rst_n    (reset),
        .ld_elr   (ld_elr),
        .ld_cause (ld_cause),
        .cnt_inc  (ld_cause),
        .elr_in   (elr_nxt),
        .esr_in   (esr_nxt),
        .err_in   (bus.PC_M),
        .sel      (bus.SysRegSel),
        .rd_dat   (bus.SysRegData),
        .elr      (elr)
    );

    assign bus.ExcAck    = (state_q == TAKE);
    assign bus.Flush     = (state_q == TAKE) || (state_q == RETURN);
    assign bus.InHandler = (state_q == HANDLER);
    assign bus.PCSel     = (state_q == TAKE)   ? PC_VEC :
                           (state_q == RETURN) ? PC_ELR : PC_SEQ;
    assign bus.ExcPC     = (state_q == TAKE)   ? EXC_VECTOR :
                           (state_q == RETURN) ? elr : '0;

endmodule
